// File: rtl/tennis_scoreboard.sv
// Tennis game/match scoring with a 4-digit multiplexed seven-segment display.
// Point pulses drive the scoring FSM; the display scans one digit per refresh period.
module tennis_scoreboard #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GAMES_TO_WIN = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       clear_match,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] games_left,
  output logic [2:0] games_right,
  output logic       match_over,
  output logic       winner
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [2:0] GW = 3'(GAMES_TO_WIN);

  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_ZERO  = 7'b1000000;

  typedef enum logic [2:0] {
    NORMAL,
    DEUCE,
    ADV_L,
    ADV_R,
    MATCH_DONE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_pl;
  logic [1:0]      r_pr;
  logic [2:0]      r_games_l;
  logic [2:0]      r_games_r;
  logic            r_match_over;
  logic            r_winner;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_dig;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_clr;
  logic            w_valid;
  logic            w_win_l;
  logic            w_win_r;
  logic [2:0]      w_gl_inc;
  logic [2:0]      w_gr_inc;
  logic [6:0]      w_lglyph;
  logic [6:0]      w_rglyph;
  logic [6:0]      w_seg;
  logic            w_dp;

  function automatic logic [6:0] f_num(input logic [2:0] v);
    logic [6:0] g;
    case (v)
      3'd0:    g = 7'b1000000;
      3'd1:    g = 7'b1111001;
      3'd2:    g = 7'b0100100;
      3'd3:    g = 7'b0110000;
      3'd4:    g = 7'b0011001;
      3'd5:    g = 7'b0010010;
      3'd6:    g = 7'b0000010;
      default: g = 7'b1111000;
    endcase
    return g;
  endfunction

  // Point index 0/1/2/3 displays as the leading digit of 0/15/30/40.
  function automatic logic [6:0] f_pt(input logic [1:0] idx);
    logic [6:0] g;
    case (idx)
      2'd0:    g = f_num(3'd0);
      2'd1:    g = f_num(3'd1);
      2'd2:    g = f_num(3'd3);
      default: g = f_num(3'd4);
    endcase
    return g;
  endfunction

  assign w_clr    = reset | clear_match;
  assign w_valid  = (point_left ^ point_right) && (r_state != MATCH_DONE);
  assign w_gl_inc = r_games_l + 3'd1;
  assign w_gr_inc = r_games_r + 3'd1;

  always_comb begin
    w_win_l = w_valid && point_left &&
              ((r_state == NORMAL && r_pl == 2'd3) || r_state == ADV_L);
    w_win_r = w_valid && point_right &&
              ((r_state == NORMAL && r_pr == 2'd3) || r_state == ADV_R);
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state      <= NORMAL;
      r_pl         <= 2'd0;
      r_pr         <= 2'd0;
      r_games_l    <= 3'd0;
      r_games_r    <= 3'd0;
      r_match_over <= 1'b0;
      r_winner     <= 1'b0;
    end else if (w_win_l) begin
      r_pl      <= 2'd0;
      r_pr      <= 2'd0;
      r_games_l <= w_gl_inc;
      if (w_gl_inc == GW) begin
        r_state      <= MATCH_DONE;
        r_match_over <= 1'b1;
        r_winner     <= 1'b1;
      end else begin
        r_state <= NORMAL;
      end
    end else if (w_win_r) begin
      r_pl      <= 2'd0;
      r_pr      <= 2'd0;
      r_games_r <= w_gr_inc;
      if (w_gr_inc == GW) begin
        r_state      <= MATCH_DONE;
        r_match_over <= 1'b1;
        r_winner     <= 1'b0;
      end else begin
        r_state <= NORMAL;
      end
    end else if (w_valid) begin
      case (r_state)
        NORMAL: begin
          if (point_left) begin
            if (r_pl == 2'd2 && r_pr == 2'd3) r_state <= DEUCE;
            else r_pl <= r_pl + 2'd1;
          end else begin
            if (r_pr == 2'd2 && r_pl == 2'd3) r_state <= DEUCE;
            else r_pr <= r_pr + 2'd1;
          end
        end
        DEUCE:   r_state <= point_left ? ADV_L : ADV_R;
        ADV_L:   r_state <= DEUCE;
        ADV_R:   r_state <= DEUCE;
        default: r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_lglyph = G_BLANK;
    w_rglyph = G_BLANK;
    case (r_state)
      NORMAL: begin
        w_lglyph = f_pt(r_pl);
        w_rglyph = f_pt(r_pr);
      end
      DEUCE: begin
        w_lglyph = G_D;
        w_rglyph = G_D;
      end
      ADV_L:   w_lglyph = G_A;
      ADV_R:   w_rglyph = G_A;
      default: ;
    endcase
  end

  always_comb begin
    w_seg = G_BLANK;
    w_dp  = 1'b1;
    case (r_dig)
      2'd3: w_seg = w_lglyph;
      2'd2: begin
        w_seg = f_num(r_games_l);
        w_dp  = ~(r_match_over & r_winner);
      end
      2'd1: begin
        w_seg = f_num(r_games_r);
        w_dp  = ~(r_match_over & ~r_winner);
      end
      default: w_seg = w_rglyph;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_an  <= 4'b1110;
      r_seg <= G_ZERO;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_dig);
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign games_left  = r_games_l;
  assign games_right = r_games_r;
  assign match_over  = r_match_over;
  assign winner      = r_winner;

endmodule

// File: tb/tb_tennis_scoreboard.sv
// Randomized bench for tennis_scoreboard against a points-count reference model.
// Model scores by raw rally counts (win at >=4 and lead >=2) and derives glyphs from that.
module tb_tennis_scoreboard;

  localparam int RD = 4;
  localparam int GW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       point_left = 1'b0;
  logic       point_right = 1'b0;
  logic       clear_match = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] games_left;
  logic [2:0] games_right;
  logic       match_over;
  logic       winner;

  tennis_scoreboard #(
    .REFRESH_DIV (RD),
    .GAMES_TO_WIN(GW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .point_left (point_left),
    .point_right(point_right),
    .clear_match(clear_match),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .games_left (games_left),
    .games_right(games_right),
    .match_over (match_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ma = 0, mb = 0, mgl = 0, mgr = 0, mtick = 0;
  bit mdone = 0, mwin = 0;

  logic [6:0] num_g [8] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  int pt_map [4] = '{0, 1, 3, 4};
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GB = 7'b1111111;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pglyph(input int me, input int op);
    if (mdone) return GB;
    if (me >= 3 && op >= 3) begin
      if (me == op) return GD;
      if (me > op) return GA;
      return GB;
    end
    return num_g[pt_map[me]];
  endfunction

  task automatic step(input bit l, input bit r, input bit c, input bit rs);
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    int d;
    point_left  = l;
    point_right = r;
    clear_match = c;
    reset       = rs;
    d = (mtick / RD) % 4;
    ean = 4'b1110; eseg = num_g[0]; edp = 1'b1;
    if (!(rs || c)) begin
      ean = ~(4'b0001 << d);
      case (d)
        3: eseg = pglyph(ma, mb);
        2: begin eseg = num_g[mgl]; edp = !(mdone && mwin); end
        1: begin eseg = num_g[mgr]; edp = !(mdone && !mwin); end
        default: eseg = pglyph(mb, ma);
      endcase
    end
    @(posedge clk);
    #1;
    if (rs || c) begin
      ma = 0; mb = 0; mgl = 0; mgr = 0; mdone = 0; mwin = 0; mtick = 0;
    end else begin
      mtick++;
      if (!mdone && (l ^ r)) begin
        if (l) ma++; else mb++;
        if (ma >= 4 && ma - mb >= 2) begin
          mgl++; ma = 0; mb = 0;
          if (mgl == GW) begin mdone = 1; mwin = 1; end
        end else if (mb >= 4 && mb - ma >= 2) begin
          mgr++; ma = 0; mb = 0;
          if (mgr == GW) begin mdone = 1; mwin = 0; end
        end
      end
    end
    chk("an", 16'(an), 16'(ean));
    chk("seg", 16'(seg), 16'(eseg));
    chk("dp", 16'(dp), 16'(edp));
    chk("games_left", 16'(games_left), 16'(mgl));
    chk("games_right", 16'(games_right), 16'(mgr));
    chk("match_over", 16'(match_over), 16'(mdone));
    if (mdone) chk("winner", 16'(winner), 16'(mwin));
    else chk("winner_clr", 16'(winner), 16'(0));
  endtask

  task automatic pts(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "L": step(1, 0, 0, 0);
        "R": step(0, 1, 0, 0);
        "B": step(1, 1, 0, 0);
        "C": step(0, 0, 1, 0);
        "X": step(0, 0, 0, 1);
        "Y": step(0, 1, 0, 1);
        default: step(0, 0, 0, 0);
      endcase
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    pts("LLLL");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
    pts("LLLRRR");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
    pts("L.......R.......LL");
    pts("LRRB");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    pts("R");
    pts("XLRLRLRR");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    pts("Y");
    pts("RRRRRRRR");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
    pts("LLLLRR");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
    pts("C");
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 1)        step(0, 0, 0, 1);
      else if (r < 3)   step(0, 0, 1, 0);
      else if (r < 60)  step(1, 0, 0, 0);
      else if (r < 117) step(0, 1, 0, 0);
      else if (r < 127) step(1, 1, 0, 0);
      else              step(0, 0, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
